// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width, subtractor state encoding and the
// per-slice result bundle used by the serial carry-lookahead subtractor.
package alu_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       c3;
    } slice_res_t;

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice with group generate/propagate.
// c3 is the carry into bit 3, needed by the caller for signed overflow.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3,
    output logic       Gg,
    output logic       Pg
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_c1;
    logic       w_c2;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c1 = w_g[0] | (w_p[0] & cin);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign Gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign Pg = &w_p;

    assign cout = Gg | (Pg & cin);
    assign sum  = w_p ^ {c3, w_c2, w_c1, cin};

endmodule

// File: rtl/serial_cla_sub.sv
// Multi-cycle subtractor: Diff = A + ~B + 1, one lookahead slice per cycle
// with the inter-slice carry registered. Flags settle on the final slice.
module serial_cla_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             Cout,
    output logic             Ovfl,
    output logic             Z,
    output logic             N,
    output logic             busy,
    output logic             done
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    sub_state_t       r_state;
    sub_state_t       w_state_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_diff;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovfl;
    logic             r_z;
    logic             r_n;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_sum;
    logic             w_cout;
    logic             w_c3;
    logic             w_gg;
    logic             w_pg;
    slice_res_t       w_slice;
    logic [WIDTH-1:0] w_full;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_nib  = r_op_a[r_idx*SLICE_W +: SLICE_W];
    assign w_b_nib  = r_op_b[r_idx*SLICE_W +: SLICE_W];

    cla_slice4 u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .c3   (w_c3),
        .Gg   (w_gg),
        .Pg   (w_pg)
    );

    assign w_slice = '{sum: w_sum, cout: w_cout, c3: w_c3};

    // Result as it will look once the current nibble is written; Z/N need it.
    always_comb begin
        w_full = r_diff;
        w_full[r_idx*SLICE_W +: SLICE_W] = w_slice.sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_diff  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovfl  <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= A;
            r_op_b  <= ~B;
            r_carry <= 1'b1;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_diff  <= w_full;
            // Inter-slice carry taken in group generate/propagate form.
            r_carry <= w_gg | (w_pg & r_carry);
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_slice.cout;
                r_ovfl <= w_slice.c3 ^ w_slice.cout;
                r_z    <= (w_full == '0);
                r_n    <= w_full[WIDTH-1];
            end
        end
    end

    assign Diff = r_diff;
    assign Cout = r_cout;
    assign Ovfl = r_ovfl;
    assign Z    = r_z;
    assign N    = r_n;
    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_cla_sub.sv
// Scoreboard bench for serial_cla_sub: a driver queues expected results from
// a plain-arithmetic model, a negedge monitor pops them on every done pulse.
module tb_serial_cla_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Diff;
    logic        Cout;
    logic        Ovfl;
    logic        Z;
    logic        N;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] diff;
        logic        cout;
        logic        ovfl;
        logic        z;
        logic        n;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    serial_cla_sub #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Diff  (Diff),
        .Cout  (Cout),
        .Ovfl  (Ovfl),
        .Z     (Z),
        .N     (N),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   sdiff;
        e.diff = a - b;
        e.cout = (a >= b);
        sdiff  = int'($signed(a)) - int'($signed(b));
        e.ovfl = (sdiff > 32767) || (sdiff < -32768);
        e.z    = (e.diff == 16'h0000);
        e.n    = e.diff[15];
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", 32'(Diff), 32'(e.diff));
                check("cout", 32'(Cout), 32'(e.cout));
                check("ovfl", 32'(Ovfl), 32'(e.ovfl));
                check("z",    32'(Z),    32'(e.z));
                check("n",    32'(N),    32'(e.n));
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
        A     = a;
        B     = b;
        start = 1'b1;
        if (push) sb.push_back(model(a, b));
    endtask

    // Called on the negedge where start was raised; returns on the done negedge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                start = 1'b0;
                A     = 16'($urandom);
                B     = 16'($urandom);
            end
            lat++;
            if (busy) busy_cnt++;
        end while (!done && lat < 20);
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit b2b);
        int lat;
        int bc;
        if (!b2b) @(negedge clk);
        issue(a, b, 1'b1);
        wait_done(lat, bc);
        check("latency", 32'(lat), 32'd5);
        check("busy_cycles", 32'(bc), 32'd4);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_flags", 32'({Cout, Ovfl, Z, N}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        rst_n = 1'b1;

        run_op(16'h0005, 16'h0003, 1'b0);
        run_op(16'h0003, 16'h0005, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b1);
        run_op(16'h1234, 16'h1234, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b0);

        // A second start while running must be ignored.
        @(negedge clk);
        issue(16'h00F0, 16'h000F, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(16'hFFFF, 16'h0000, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n = 3;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ignored_start_latency", 32'(n), 32'd5);
        repeat (8) @(negedge clk);
        check("single_done", 32'(sb.size()), 32'd0);

        // Reset during RUN aborts the op with no result and no done.
        run_op(16'h8000, 16'h0001, 1'b0);
        @(negedge clk);
        issue(16'h4321, 16'h1111, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_diff", 32'(Diff), 32'd0);
        check("abort_flags", 32'({Cout, Ovfl, Z, N}), 32'd0);
        check("abort_busy_done", 32'({busy, done}), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("abort_idle", 32'({busy, done}), 32'd0);
        end
        run_op(16'h0010, 16'h0001, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = ra;
                1:       rb = 16'h0000;
                2:       rb = ra ^ 16'h8000;
                default: rb = 16'($urandom);
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_cla_sub.md
Name: serial_cla_sub

Overview:
Multi-cycle 16-bit subtractor for the ALU. Computes Diff = A - B as A + ~B + 1, one 4-bit carry-lookahead slice per cycle, with the carry registered between slices. Produces carry/borrow, overflow, zero and negative flags for the compare/branch path. Uses a start/busy/done handshake so the control unit can issue back-to-back operations.

Parameters:
WIDTH, 16, operand and result width; must be a multiple of SLICE_W
SLICE_W, 4, bits resolved per cycle by the lookahead slice
NSLICE, WIDTH/SLICE_W (4), number of slice cycles per operation (derived, localparam)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request a new subtract; sampled only in IDLE or DONE
A  input  WIDTH  minuend; captured on an accepted start
B  input  WIDTH  subtrahend; captured on an accepted start
Diff  output  WIDTH  result, held stable from done until the next accepted start
Cout  output  1  carry out of the MSB; 1 = no borrow (A >= B unsigned)
Ovfl  output  1  signed overflow: carry into MSB xor carry out of MSB
Z  output  1  Diff == 0
N  output  1  Diff[WIDTH-1]
busy  output  1  high while slices are being computed
done  output  1  one-cycle pulse when Diff and the flags become valid

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; Diff, Cout, Ovfl, Z, N, busy and done all 0; slice index 0; carry register 0. Reset mid-operation aborts the operation. No partial result is visible, and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch A to opA and ~B to opB, set carry=1 and idx=0, then go to RUN. Diff and the flags keep their previous values.
- RUN: busy=1. Each cycle, slice idx adds opA[idx] + opB[idx] + carry through the lookahead slice. The sum nibble is written into Diff bits [idx*SLICE_W +: SLICE_W], carry takes the slice carry-out, and idx increments.
  - On the cycle idx = NSLICE-1: Cout = slice carry-out, Ovfl = (carry into bit WIDTH-1) xor (slice carry-out), Z and N are computed from the complete result, and the state goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE is accepted as in IDLE and goes straight to RUN (back-to-back, no idle bubble).
  - Otherwise the state goes to IDLE.
- Latency: start accepted at edge k; done=1 during the cycle after edge k+NSLICE (4 slice cycles). Throughput is one operation per NSLICE+1 cycles.
- start while in RUN is ignored. Operands do not change, and no queueing takes place.
- A and B may change freely after acceptance.
- Diff is updated nibble by nibble during RUN and is valid only when done=1 or after done. Z, N, Cout and Ovfl update only on the final slice.
- Arithmetic is modular WIDTH-bit; there is no saturation.
- Boundary cases:
  - 0 - 0 gives Cout=1, Z=1.
  - A = B gives Cout=1, Z=1, Ovfl=0.
  - 0x8000 - 0x0001 sets Ovfl.

Decomposition:
- Shared package alu_pkg:
  - SLICE_W constant
  - state enum typedef sub_state_t {IDLE, RUN, DONE}
  - slice result struct typedef: sum[3:0], cout, c3 (carry into the slice MSB)
- One sub-module, cla_slice4: a combinational 4-bit lookahead slice with generate/propagate.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c3 (carry into bit 3), Gg, Pg.
  - The top level instantiates it once and multiplexes nibbles into it by idx.

Test Plan:
- A=0x0005, B=0x0003, start for 1 cycle -> done 5 cycles later; Diff=0x0002, Cout=1, Z=0, N=0, Ovfl=0; busy high for exactly 4 cycles.
- A=0x0003, B=0x0005 -> Diff=0xFFFE, Cout=0, N=1, Z=0, Ovfl=0.
- A=0x8000, B=0x0001 -> Diff=0x7FFF, Ovfl=1, Cout=1, N=0; then A=0x7FFF, B=0xFFFF -> Diff=0x8000, Ovfl=1, Cout=0, N=1.
- A=0x1234, B=0x1234 -> Diff=0x0000, Z=1, Cout=1; this is issued as a back-to-back start during DONE of the previous op and must complete without a gap cycle.
- start pulsed again with A=0xFFFF, B=0x0000 two cycles into a running op (A=0x00F0, B=0x000F) -> second start ignored; Diff=0x00E1, exactly one done pulse.
- rst_n=0 for one edge during RUN -> next cycle all outputs 0, state IDLE, no done; a following op A=0x0010, B=0x0001 yields Diff=0x000F.
